// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU with iterative multiply/divide.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLT   = 4'd5,
    OP_SLL   = 4'd6,
    OP_SRL   = 4'd7,
    OP_SRA   = 4'd8,
    OP_SLTU  = 4'd9,
    OP_PASSB = 4'd10,
    OP_MUL   = 4'd11,
    OP_MULHU = 4'd12,
    OP_DIVU  = 4'd13,
    OP_REMU  = 4'd14,
    OP_RSVD  = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  function automatic logic is_muldiv(alu_op_t op);
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Bit-serial unsigned multiply (shift-add) and restoring divide sharing one
// 2W accumulator: {hi, lo} = {product hi, product lo} or {remainder, quotient}.
module muldiv_iter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush_i,
  input  logic         start_i,
  input  logic         is_div_i,
  input  logic         hi_sel_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         done_o,
  output logic [W-1:0] result_o
);

  localparam int CW = $clog2(W);

  logic [2*W-1:0] acc_q, acc_d, mul_nxt, div_nxt;
  logic [W-1:0]   b_q;
  logic [CW-1:0]  cnt_q;
  logic           active_q, is_div_q, hi_sel_q;
  logic [W:0]     sum, sh, diff;

  always_comb begin
    sum     = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_nxt = {sum, acc_q[W-1:1]};
    // Partial remainder shifted left with the next dividend bit from lo.
    sh      = {acc_q[2*W-1:W], acc_q[W-1]};
    diff    = sh - {1'b0, b_q};
    if (sh >= {1'b0, b_q}) div_nxt = {diff[W-1:0], acc_q[W-2:0], 1'b1};
    else                   div_nxt = {sh[W-1:0],   acc_q[W-2:0], 1'b0};
    acc_d   = is_div_q ? div_nxt : mul_nxt;
  end

  // Result is taken from the final step's next value so it lands with done.
  assign result_o = hi_sel_q ? acc_d[2*W-1:W] : acc_d[W-1:0];
  assign done_o   = active_q && (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      is_div_q <= 1'b0;
      hi_sel_q <= 1'b0;
    end else if (flush_i) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (start_i) begin
      acc_q    <= {{W{1'b0}}, a_i};
      b_q      <= b_i;
      cnt_q    <= CW'(W-1);
      active_q <= 1'b1;
      is_div_q <= is_div_i;
      hi_sel_q <= hi_sel_i;
    end else if (active_q) begin
      acc_q <= acc_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) active_q <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_alu_md.sv
// Execute-stage ALU: single-cycle integer ops plus iterative MUL/MULHU/DIVU/REMU
// behind a valid/ready handshake; busy_o stalls the front of the pipe.
module exec_alu_md
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [ALU_OP_W-1:0]   op_i,
  input  logic [DATA_WIDTH-1:0] src_a_i,
  input  logic [DATA_WIDTH-1:0] src_b_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  out_valid_o,
  output logic                  eq_o,
  output logic                  busy_o
);

  alu_state_t            state_q, state_d;
  alu_op_t               op;
  logic [DATA_WIDTH-1:0] result_q, alu_res, md_res;
  logic [SHAMT_W-1:0]    shamt;
  logic                  eq_q, accept, div_zero, md_start, md_done;

  assign op       = alu_op_t'(op_i);
  assign shamt    = src_b_i[SHAMT_W-1:0];
  assign accept   = in_valid_i && in_ready_o && !flush_i;
  assign div_zero = ((op == OP_DIVU) || (op == OP_REMU)) && (src_b_i == '0);
  assign md_start = accept && is_muldiv(op) && !div_zero;

  // Divide-by-zero results are produced here so they take the 1-cycle path.
  always_comb begin
    alu_res = src_b_i;
    case (op)
      OP_ADD:  alu_res = src_a_i + src_b_i;
      OP_SUB:  alu_res = src_a_i - src_b_i;
      OP_AND:  alu_res = src_a_i & src_b_i;
      OP_OR:   alu_res = src_a_i | src_b_i;
      OP_XOR:  alu_res = src_a_i ^ src_b_i;
      OP_SLT:  alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(src_a_i) < $signed(src_b_i)};
      OP_SLL:  alu_res = src_a_i << shamt;
      OP_SRL:  alu_res = src_a_i >> shamt;
      OP_SRA:  alu_res = $signed(src_a_i) >>> shamt;
      OP_SLTU: alu_res = {{(DATA_WIDTH-1){1'b0}}, src_a_i < src_b_i};
      OP_DIVU: alu_res = '1;
      OP_REMU: alu_res = src_a_i;
      default: alu_res = src_b_i;
    endcase
  end

  muldiv_iter #(.W(DATA_WIDTH)) u_md (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (flush_i),
    .start_i  (md_start),
    .is_div_i ((op == OP_DIVU) || (op == OP_REMU)),
    .hi_sel_i ((op == OP_MULHU) || (op == OP_REMU)),
    .a_i      (src_a_i),
    .b_i      (src_b_i),
    .done_o   (md_done),
    .result_o (md_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) state_d = IDLE;
    else begin
      case (state_q)
        RUN:     state_d = md_done ? DONE : RUN;
        default: state_d = accept ? (md_start ? RUN : DONE) : IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready_o  = (state_q != RUN);
    busy_o      = (state_q == RUN);
    out_valid_o = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      eq_q     <= 1'b0;
    end else begin
      if (accept) eq_q <= (src_a_i == src_b_i);
      if (accept && !md_start)                         result_q <= alu_res;
      else if (!flush_i && state_q == RUN && md_done)  result_q <= md_res;
    end
  end

  assign result_o = result_q;
  assign eq_o     = eq_q;

endmodule
